// File: rtl/jtframe_db15_pkg.sv
// Shared types and helpers for the DB15/SNAC serial joystick reader.
// Latency: none (declarations only).
// Backpressure: not applicable.
package jtframe_db15_pkg;

   // Widest chain the reader supports (PLAYERS*BITS)
   localparam int MAX_W = 48;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_LOW,
      ST_HIGH,
      ST_DONE,
      ST_WAIT
   } state_t;

   // Number of serial bits clocked out for n joysticks of 'bits' buttons
   function automatic int calc_nb(input int n, input int bits);
      return n * bits;
   endfunction

endpackage

// File: rtl/jtframe_db15_debounce.sv
// Debouncer: publishes the shadow word once DEBOUNCE identical scans are seen.
// Latency: the word updates on the same edge as the strobe that qualifies it.
// Backpressure: none; a strobe is consumed on the cycle it arrives.
module jtframe_db15_debounce
   import jtframe_db15_pkg::*;
#(
   parameter int W        = 24,
   parameter int DEBOUNCE = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         strobe,
   input  logic         clear,
   input  logic [W-1:0] raw,
   input  logic [W-1:0] mask,
   output logic [W-1:0] word
);
   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [W-1:0]  shadow_q, shadow_d;
   logic [W-1:0]  word_q, word_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  raw_m;

   // Match counting; unused chain bits are always forced to zero
   always_comb begin
      raw_m    = raw & mask;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      if (clear) begin
         cnt_d  = '0;
         word_d = '0;
      end else if (strobe) begin
         if (raw_m == shadow_q) begin
            if (cnt_q < CW'(DEBOUNCE)) cnt_d = cnt_q + 1'b1;
         end else begin
            shadow_d = raw_m;
            cnt_d    = CW'(1);
         end
         word_d = (cnt_d >= CW'(DEBOUNCE)) ? shadow_d : (word_q & mask);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         word_q   <= '0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
      end
   end

   assign word = word_q;

endmodule

// File: rtl/jtframe_db15_reader.sv
// DB15/SNAC reader: loads the adapter shift chain, clocks out n*BITS bits, debounces.
// Latency: 2*CLKDIV*n*BITS cycles from LOAD to DONE; outputs are registered.
// Backpressure: none; free-running scans every SCAN_PERIOD cycles, players_on=0 aborts.
module jtframe_db15_reader
   import jtframe_db15_pkg::*;
#(
   parameter int PLAYERS     = 2,
   parameter int BITS        = 12,
   parameter int CLKDIV      = 24,
   parameter int SCAN_PERIOD = 50000,
   parameter int DEBOUNCE    = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [$clog2(PLAYERS+1)-1:0] players_on,
   input  logic                         joy_data,
   output logic                         joy_clk,
   output logic                         joy_load,
   output logic [PLAYERS*BITS-1:0]      joystick,
   output logic                         scan_done,
   output logic                         busy
);
   localparam int W  = PLAYERS * BITS;
   localparam int PW = $clog2(PLAYERS + 1);
   localparam int BI = (W > 1) ? $clog2(W) : 1;
   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int SW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [BI-1:0] bit_q, bit_d;
   logic [BI-1:0] last_q, last_d;
   logic [SW-1:0] per_q, per_d;
   logic [W-1:0]  raw_q, raw_d;
   logic          joy_clk_q, joy_clk_d;
   logic          joy_load_q, joy_load_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [PW-1:0] n_eff;
   logic          phase_end, per_end, abort;
   logic [W-1:0]  mask;

   // Next-state, sampling, counters and registered-output decode
   always_comb begin
      n_eff      = (players_on > PW'(PLAYERS)) ? PW'(PLAYERS) : players_on;
      phase_end  = (div_q == DW'(CLKDIV - 1));
      per_end    = (per_q == SW'(SCAN_PERIOD - 1));
      abort      = (players_on == '0) && (state_q != ST_IDLE);
      state_d    = state_q;
      bit_d      = bit_q;
      last_d     = last_q;
      raw_d      = raw_q;
      per_d      = per_end ? per_q : per_q + 1'b1;
      case (state_q)
         ST_IDLE:   if (n_eff != '0) state_d = ST_LOAD;
         ST_LOAD:   if (phase_end) state_d = ST_SETTLE;
         ST_SETTLE: if (phase_end) begin
            raw_d[0] = ~joy_data;
            bit_d    = BI'(1);
            state_d  = (last_q == '0) ? ST_DONE : ST_LOW;
         end
         ST_LOW:    if (phase_end) state_d = ST_HIGH;
         ST_HIGH:   if (phase_end) begin
            raw_d[bit_q] = ~joy_data;
            if (bit_q == last_q) begin
               state_d = ST_DONE;
            end else begin
               bit_d   = bit_q + 1'b1;
               state_d = ST_LOW;
            end
         end
         ST_DONE:   state_d = ST_WAIT;
         ST_WAIT:   if (per_end) state_d = ST_LOAD;
         default:   state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
      // Player count is frozen for the whole scan on LOAD entry
      if (state_d == ST_LOAD && state_q != ST_LOAD) begin
         last_d = BI'(calc_nb(int'(n_eff), BITS) - 1);
         per_d  = '0;
         bit_d  = '0;
         raw_d  = '0;
      end
      div_d = div_q + 1'b1;
      if (state_d != state_q || !(state_d inside {ST_LOAD, ST_SETTLE, ST_LOW, ST_HIGH}))
         div_d = '0;
      joy_clk_d  = (state_d != ST_LOW);
      joy_load_d = (state_d != ST_LOAD);
      busy_d     = state_d inside {ST_LOAD, ST_SETTLE, ST_LOW, ST_HIGH, ST_DONE};
      done_d     = (state_d == ST_DONE);
   end

   // Valid-bit mask for the chain length latched at LOAD
   always_comb begin
      mask = '0;
      for (int i = 0; i < W; i++) mask[i] = (i <= int'(last_q));
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         last_q     <= '0;
         per_q      <= '0;
         raw_q      <= '0;
         joy_clk_q  <= 1'b1;
         joy_load_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         last_q     <= last_d;
         per_q      <= per_d;
         raw_q      <= raw_d;
         joy_clk_q  <= joy_clk_d;
         joy_load_q <= joy_load_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // The freshly completed word is handed over on the edge that enters DONE
   jtframe_db15_debounce #(
      .W        (W),
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .strobe (state_d == ST_DONE),
      .clear  (abort),
      .raw    (raw_d),
      .mask   (mask),
      .word   (joystick)
   );

   assign joy_clk   = joy_clk_q;
   assign joy_load  = joy_load_q;
   assign busy      = busy_q;
   assign scan_done = done_q;

endmodule

// File: doc/jtframe_db15_reader.md
Name: jtframe_db15_reader

Overview:
- Parametrised serial reader for DB15/SNAC joystick adapters on the MiSTer user port.
- Drives the adapter's shift-register load/clock lines and deserialises 1..PLAYERS joysticks of BITS buttons each.
- Debounces the data and presents active-high joystick words to the frame's input mux.
- Replaces the fixed 1/2-player reader; adds player count, bit width, clock rate, scan period and debounce depth as parameters.

Parameters:
- PLAYERS, 2: maximum joysticks in the chain. Range 1..4.
- BITS, 12: buttons per joystick. PLAYERS*BITS must not exceed 48.
- CLKDIV, 24: clk cycles per joy_clk half-period. Must be ≥1.
- SCAN_PERIOD, 50000: clk cycles from one scan start to the next. A longer scan restarts immediately.
- DEBOUNCE, 2: consecutive identical scans required before the output updates. Must be ≥1; 1 means no debounce.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- players_on, input, $clog2(PLAYERS+1): number of joysticks to read. 0 disables the reader. Values above PLAYERS saturate to PLAYERS.
- joy_data, input, 1: serial data from the adapter. Active-low buttons.
- joy_clk, output, 1: shift clock to the adapter.
- joy_load, output, 1: parallel-load strobe to the adapter. Active-low.
- joystick, output, PLAYERS*BITS: debounced active-high buttons. Player p occupies bits [p*BITS +: BITS].
- scan_done, output, 1: one-cycle pulse when a scan completes.
- busy, output, 1: high from LOAD through DONE.

Behaviour:
- Reset values: joy_clk=1, joy_load=1, joystick=0, scan_done=0, busy=0. FSM in IDLE; period counter, debounce counter and shadow registers cleared.
- Effective player count: n = min(players_on, PLAYERS); NB = n*BITS. n is latched on entry to LOAD and held for the whole scan.
- States: IDLE, LOAD, SETTLE, LOW, HIGH, DONE, WAIT.
- IDLE: leave when n≠0, going to LOAD.
- LOAD: joy_load=0, joy_clk=1, for CLKDIV cycles. The period counter restarts on entry. Next state SETTLE.
- SETTLE: joy_load=1 for CLKDIV cycles. joy_data is sampled on the last cycle as bit 0. If NB=1, go to DONE; otherwise go to LOW.
- LOW: joy_clk=0 for CLKDIV cycles, then HIGH.
- HIGH: joy_clk=1 for CLKDIV cycles. The next bit is sampled on the last cycle. When the sampled bit is NB-1, go to DONE; otherwise go to LOW.
- Bit k of the raw scan is the k-th sample. Raw data is stored inverted, so pressed = 1.
- Scan length from LOAD entry to DONE: 2*CLKDIV + (NB-1)*2*CLKDIV cycles. DONE lasts 1 cycle.
- DONE: scan_done=1.
  - If raw == shadow, the debounce count increments, saturating at DEBOUNCE. Otherwise shadow <= raw and count <= 1.
  - When count ≥ DEBOUNCE (after the update), joystick <= shadow with bits ≥ NB forced to 0.
  - Bits ≥ NB are also forced to 0 immediately at DONE, even without a debounce match.
  - Next state WAIT.
- WAIT: go to LOAD when the period counter reaches SCAN_PERIOD-1. If the counter already expired during the scan, go to LOAD on the next cycle.
- players_on dropping to 0 in any state except IDLE: abort to IDLE the next cycle.
  - joy_clk=1, joy_load=1, busy=0.
  - joystick cleared to 0 in the same cycle the abort is registered.
  - Debounce count reset to 0.
- players_on changing to a nonzero value mid-scan: ignored until the next LOAD.
- Asynchronous reset mid-scan: all outputs return to reset values immediately. No partial data is ever presented.
- Output registers: all outputs are registered, with no combinational path from joy_data or players_on.

Decomposition:
- Package jtframe_db15_pkg: state enum (IDLE..WAIT), maximum chain width constant (48), and a function computing NB from n and BITS.
- Sub-module jtframe_db15_debounce, parameters W and DEBOUNCE:
  - holds the shadow register and the saturating match counter;
  - inputs: raw, mask, strobe;
  - output: the registered word.
- The top module holds the FSM, the CLKDIV prescaler, the bit counter and the period counter.

Test Plan:
1. Reset and idle. Set CLKDIV=2, PLAYERS=2, BITS=12, players_on=0, then release rst_n. Required: joy_clk=1, joy_load=1, joystick=0 and busy=0 held for 1000 cycles.
2. Single-player scan. Set players_on=1, DEBOUNCE=1, and drive a model with P1 buttons 0x0A5 pressed. Required:
   - joy_load is low for 2 cycles;
   - 11 joy_clk low pulses, each 2 cycles wide;
   - scan_done pulses 48 cycles after LOAD entry;
   - joystick[11:0]=0x0A5 and joystick[23:12]=0.
3. Two players with debounce. Set players_on=2, DEBOUNCE=2, P1=0x001, P2=0x800. Required:
   - joystick stays 0 after the first scan;
   - joystick=0x800_001 after the second scan;
   - a glitch of P2 to 0x000 on one scan only leaves the output unchanged.
4. Saturation. Set players_on=3 with PLAYERS=2. Required: behaviour identical to players_on=2, i.e. 23 clock pulses per scan.
5. Abort. Drop players_on from 2 to 0 during a HIGH phase. Required:
   - the next cycle has joy_clk=1, joy_load=1 and busy=0;
   - joystick=0 at the same time;
   - restoring players_on=2 starts a fresh LOAD.
6. Period overrun. Set SCAN_PERIOD=10 with a 96-cycle two-player scan. Required: LOAD re-entered exactly 2 cycles after each scan_done (DONE, then 1 WAIT cycle). Assert rst_n low mid-scan. Required: outputs return to their reset values asynchronously.
